number_generator: RTL

NUMBER_GENERATOR -- requirements
Module: number_generator

---
 rtl/number_generator.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/number_generator.sv
// Reaction-game target generator: presents LFSR numbers, confirms a debounced match
// from the comparator, and scores hits against a per-round timeout.
//
// state   | meaning
// IDLE    | no game; waiting for start
// LOAD    | fetching a fresh number that differs from the previous one
// PRESENT | number shown; blanking, then waiting for is_equal
// CONFIRM | is_equal seen; counting consecutive equal cycles
module number_generator #(
    parameter logic [7:0] SEED           = 8'hA5,
    parameter int         CONFIRM_CYCLES = 4,
    parameter int         BLANK_CYCLES   = 2,
    parameter int         TIMEOUT_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       is_equal,
    output logic [7:0] number,
    output logic       number_valid,
    output logic [7:0] score,
    output logic       hit,
    output logic       miss
);

    localparam int             TW           = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TIMER_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  TIMER_ONE    = TW'(1);
    localparam logic [7:0]     CONFIRM_LAST = 8'(CONFIRM_CYCLES - 1);
    localparam logic [3:0]     BLANK_LOAD   = 4'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2,
        CONFIRM = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [7:0]    number_q, number_d;
    logic          valid_q, valid_d;
    logic [7:0]    score_q, score_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic [3:0]    blank_q, blank_d;
    logic [7:0]    confirm_q, confirm_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          timeout;
    logic          do_hit;
    logic          do_miss;
    logic [7:0]    score_inc;

    always_comb begin
        state_d   = state_q;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        number_d  = number_q;
        valid_d   = valid_q;
        score_d   = score_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        blank_d   = blank_q;
        confirm_d = confirm_q;
        timer_d   = timer_q;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        timeout   = (timer_q == TIMER_LAST);
        score_inc = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;

        if (stop) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            blank_d   = 4'd0;
            confirm_d = 8'd0;
            timer_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    if (start) begin
                        state_d = LOAD;
                        score_d = 8'd0;
                    end
                end
                LOAD: begin
                    // Never repeat the previous target back to back
                    if (lfsr_q != number_q) begin
                        number_d  = lfsr_q;
                        valid_d   = 1'b1;
                        blank_d   = BLANK_LOAD;
                        confirm_d = 8'd0;
                        timer_d   = '0;
                        state_d   = PRESENT;
                    end
                end
                PRESENT: begin
                    if (blank_q != 4'd0) begin
                        blank_d = blank_q - 4'd1;
                    end
                    if (blank_q == 4'd0 && is_equal && CONFIRM_CYCLES == 1) begin
                        do_hit = 1'b1;
                    end else if (timeout) begin
                        do_miss = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                        if (blank_q == 4'd0 && is_equal) begin
                            confirm_d = 8'd1;
                            state_d   = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (is_equal && confirm_q == CONFIRM_LAST) begin
                        do_hit = 1'b1;
                    end else if (timeout) begin
                        do_miss = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                        if (is_equal) begin
                            confirm_d = confirm_q + 8'd1;
                        end else begin
                            confirm_d = 8'd0;
                            state_d   = PRESENT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // A hit takes precedence over a timeout on the same cycle
            if (do_hit) begin
                hit_d     = 1'b1;
                score_d   = score_inc;
                valid_d   = 1'b0;
                confirm_d = 8'd0;
                state_d   = LOAD;
            end else if (do_miss) begin
                miss_d    = 1'b1;
                valid_d   = 1'b0;
                confirm_d = 8'd0;
                state_d   = LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            number_q  <= 8'd0;
            valid_q   <= 1'b0;
            score_q   <= 8'd0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            blank_q   <= 4'd0;
            confirm_q <= 8'd0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            number_q  <= number_d;
            valid_q   <= valid_d;
            score_q   <= score_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            blank_q   <= blank_d;
            confirm_q <= confirm_d;
            timer_q   <= timer_d;
        end
    end

    assign number       = number_q;
    assign number_valid = valid_q;
    assign score        = score_q;
    assign hit          = hit_q;
    assign miss         = miss_q;

endmodule
